// File: rtl/clk_tick_gen_if.sv
// Control and status bundle between the RTC timebase and its consumers.
// The slave modport belongs to clk_tick_gen. The master modport belongs to whatever drives the controls.
interface clk_tick_gen_if #(
   parameter int unsigned SCAN_W = 3
);
   logic              test_i;
   logic              en_i;
   logic              clr_i;
   logic              tick_o;
   logic              blink_o;
   logic              test_o;
   logic [SCAN_W-1:0] scan_o;
   logic              scan_tick_o;

   modport slave (
      input  test_i, en_i, clr_i,
      output tick_o, blink_o, test_o, scan_o, scan_tick_o
   );

   modport master (
      output test_i, en_i, clr_i,
      input  tick_o, blink_o, test_o, scan_o, scan_tick_o
   );
endinterface

// File: rtl/clk_tick_gen.sv
// RTC display timebase. It produces a time-advance tick at the normal or fast test rate and a 50 % blink.
// It also produces a multiplexed-display scan index with its own prescaler.
module clk_tick_gen #(
   parameter int unsigned DIV_NORM = 100000000,
   parameter int unsigned DIV_FAST = 10,
   parameter int unsigned DIV_SCAN = 25000,
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned SCAN_W   = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   clk_tick_gen_if.slave bus
);

   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0]  NORM_LAST = CNT_W'(DIV_NORM - 1);
   localparam logic [CNT_W-1:0]  FAST_LAST = CNT_W'(DIV_FAST - 1);
   localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(DIV_SCAN - 1);
   localparam logic [CNT_W-1:0]  BLINK_ON  = CNT_W'(DIV_NORM / 2);
   localparam logic [SCAN_W-1:0] DIG_LAST  = SCAN_W'(N_DIGITS - 1);

   logic              r_test_meta;
   logic              r_test;
   logic              r_test_d;
   logic [CNT_W-1:0]  r_cn;
   logic [CNT_W-1:0]  r_cf;
   logic [CNT_W-1:0]  r_cs;
   logic              r_tick;
   logic              r_blink;
   logic [SCAN_W-1:0] r_scan;
   logic              r_scan_tick;

   logic w_mode_chg;
   logic w_cn_wrap;
   logic w_cf_wrap;
   logic w_cs_wrap;

   assign w_mode_chg = r_test ^ r_test_d;
   assign w_cn_wrap  = (r_cn == NORM_LAST);
   assign w_cf_wrap  = (r_cf == FAST_LAST);
   assign w_cs_wrap  = (r_cs == SCAN_LAST);

   // Two-stage synchroniser for the raw button, plus a delayed copy for edge detection
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_test_meta <= 1'b0;
         r_test      <= 1'b0;
         r_test_d    <= 1'b0;
      end else begin
         r_test_meta <= bus.test_i;
         r_test      <= r_test_meta;
         r_test_d    <= r_test;
      end
   end

   // Tick and blink path. A mode switch restarts the fast phase but never disturbs cn.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cn    <= '0;
         r_cf    <= '0;
         r_tick  <= 1'b0;
         r_blink <= 1'b0;
      end else if (bus.clr_i) begin
         r_cn    <= '0;
         r_cf    <= '0;
         r_tick  <= 1'b0;
         r_blink <= 1'b0;
      end else begin
         r_blink <= (r_cn >= BLINK_ON);
         r_tick  <= bus.en_i & ~w_mode_chg & (r_test ? w_cf_wrap : w_cn_wrap);
         if (bus.en_i) begin
            r_cn <= w_cn_wrap ? '0 : r_cn + CNT_W'(1);
         end
         if (w_mode_chg) begin
            r_cf <= '0;
         end else if (bus.en_i) begin
            r_cf <= w_cf_wrap ? '0 : r_cf + CNT_W'(1);
         end
      end
   end

   // Free-running scan prescaler and digit index
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cs        <= '0;
         r_scan      <= '0;
         r_scan_tick <= 1'b0;
      end else begin
         r_scan_tick <= w_cs_wrap;
         if (w_cs_wrap) begin
            r_cs   <= '0;
            r_scan <= (r_scan == DIG_LAST) ? '0 : r_scan + SCAN_W'(1);
         end else begin
            r_cs   <= r_cs + CNT_W'(1);
         end
      end
   end

   assign bus.tick_o      = r_tick;
   assign bus.blink_o     = r_blink;
   assign bus.test_o      = r_test;
   assign bus.scan_o      = r_scan;
   assign bus.scan_tick_o = r_scan_tick;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboarded bench for clk_tick_gen. A cycle model pushes the expected outputs for each cycle.
// Each scenario task pops and compares them, and also checks its own tick and scan timing.
module tb_clk_tick_gen;

   localparam int unsigned DN = 10;
   localparam int unsigned DF = 3;
   localparam int unsigned DS = 4;
   localparam int unsigned ND = 3;
   localparam int unsigned SW = 2;

   typedef struct packed {
      logic          tick;
      logic          blink;
      logic          test;
      logic [SW-1:0] scan;
      logic          stk;
   } out_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   out_t sb[$];

   // cycle model state
   int m_cn, m_cf, m_cs, m_scan;
   bit m_s1, m_test, m_test_d;

   clk_tick_gen_if #(.SCAN_W(SW)) bus ();

   clk_tick_gen #(
      .DIV_NORM(DN), .DIV_FAST(DF), .DIV_SCAN(DS), .N_DIGITS(ND), .SCAN_W(SW)
   ) u_dut (
      .clk_i(clk),
      .rst_i(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic model_reset;
      m_cn = 0; m_cf = 0; m_cs = 0; m_scan = 0;
      m_s1 = 0; m_test = 0; m_test_d = 0;
      sb.delete();
   endtask

   // Drive one cycle of inputs, push the model prediction, then sample the DUT after the edge
   task automatic run_cycle(input logic t, input logic e, input logic c, output out_t act);
      out_t ex;
      bit   chg;
      bus.test_i = t; bus.en_i = e; bus.clr_i = c;
      chg      = (m_test != m_test_d);
      ex.tick  = !c && !chg && e && (m_test ? (m_cf == DF-1) : (m_cn == DN-1));
      ex.blink = !c && (m_cn >= DN/2);
      ex.stk   = (m_cs == DS-1);
      ex.scan  = ex.stk ? SW'((m_scan + 1) % ND) : SW'(m_scan);
      ex.test  = m_s1;
      m_cn     = c ? 0 : (e ? (m_cn + 1) % DN : m_cn);
      m_cf     = (c || chg) ? 0 : (e ? (m_cf + 1) % DF : m_cf);
      m_cs     = (m_cs + 1) % DS;
      m_scan   = int'(ex.scan);
      m_test_d = m_test; m_test = m_s1; m_s1 = t;
      sb.push_back(ex);
      @(posedge clk); #1;
      act = {bus.tick_o, bus.blink_o, bus.test_o, bus.scan_o, bus.scan_tick_o};
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      bus.test_i = 1'b0; bus.en_i = 1'b0; bus.clr_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      out_t act;
      rst_n = 1'b0;
      bus.test_i = 1'b1; bus.en_i = 1'b1; bus.clr_i = 1'b0;
      repeat (3) @(negedge clk);
      act = {bus.tick_o, bus.blink_o, bus.test_o, bus.scan_o, bus.scan_tick_o};
      n_cmp++;
      if (act !== '0) begin
         n_bad++; $display("FAIL reset_outputs act=%b exp=%b", act, 6'b0);
      end
      do_reset();
   endtask

   task automatic test_normal(input string tag);
      out_t act, ex;
      int   n_tick, n_blink;
      n_tick = 0; n_blink = 0;
      for (int k = 1; k <= 40; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL %s_cycle k=%0d act=%b exp=%b", tag, k, act, ex);
         end
         if (act.tick) begin
            n_tick++;
            n_cmp++;
            if (k % 10 != 0) begin
               n_bad++; $display("FAIL %s_tick_pos k=%0d exp multiple of 10", tag, k);
            end
         end
         if (act.blink) n_blink++;
      end
      n_cmp++;
      if (n_tick != 4) begin
         n_bad++; $display("FAIL %s_tick_count act=%0d exp=4", tag, n_tick);
      end
      n_cmp++;
      if (n_blink != 20) begin
         n_bad++; $display("FAIL %s_blink_high act=%0d exp=20", tag, n_blink);
      end
   endtask

   task automatic test_scan;
      out_t act, ex;
      int   n_stk;
      n_stk = 0;
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL scan_cycle k=%0d act=%b exp=%b", k, act, ex);
         end
         n_cmp++;
         if (act.scan !== SW'((k / 4) % 3)) begin
            n_bad++; $display("FAIL scan_value k=%0d act=%0d exp=%0d", k, act.scan, (k / 4) % 3);
         end
         if (act.stk) n_stk++;
      end
      n_cmp++;
      if (n_stk != 10) begin
         n_bad++; $display("FAIL scan_tick_count act=%0d exp=10", n_stk);
      end
   endtask

   task automatic test_mode;
      out_t act, ex;
      int   rise, last, n_fast, n_norm;
      rise = -1; last = -1; n_fast = 0; n_norm = 0;
      do_reset();
      for (int k = 1; k <= 13; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL mode_pre k=%0d act=%b exp=%b", k, act, ex);
         end
      end
      for (int k = 1; k <= 24; k++) begin
         run_cycle(1'b1, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL mode_fast k=%0d act=%b exp=%b", k, act, ex);
         end
         if (act.test && rise < 0) rise = k;
         if (act.tick) begin
            n_fast++;
            if (last >= 0) begin
               n_cmp++;
               if (k - last != 3) begin
                  n_bad++; $display("FAIL mode_fast_gap act=%0d exp=3", k - last);
               end
            end
            last = k;
         end
      end
      n_cmp++;
      if (rise != 2) begin
         n_bad++; $display("FAIL mode_sync_latency act=%0d exp=2", rise);
      end
      n_cmp++;
      if (n_fast != 7) begin
         n_bad++; $display("FAIL mode_fast_count act=%0d exp=7", n_fast);
      end
      last = -1;
      for (int k = 1; k <= 35; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL mode_back k=%0d act=%b exp=%b", k, act, ex);
         end
         if (act.tick && k >= 4) begin
            n_norm++;
            if (last >= 0) begin
               n_cmp++;
               if (k - last != 10) begin
                  n_bad++; $display("FAIL mode_norm_gap act=%0d exp=10", k - last);
               end
            end
            last = k;
         end
      end
      n_cmp++;
      if (n_norm != 3) begin
         n_bad++; $display("FAIL mode_norm_count act=%0d exp=3", n_norm);
      end
   endtask

   task automatic test_enable;
      out_t act, ex;
      int   first, n_stk;
      first = -1; n_stk = 0;
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL en_pre k=%0d act=%b exp=%b", k, act, ex);
         end
      end
      for (int k = 18; k <= 24; k++) begin
         run_cycle(1'b0, 1'b0, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL en_hold k=%0d act=%b exp=%b", k, act, ex);
         end
         n_cmp++;
         if (act.tick !== 1'b0 || act.blink !== 1'b1) begin
            n_bad++; $display("FAIL en_frozen k=%0d tick=%b blink=%b exp tick=0 blink=1", k, act.tick, act.blink);
         end
         if (act.stk) n_stk++;
      end
      n_cmp++;
      if (n_stk != 2) begin
         n_bad++; $display("FAIL en_scan_running act=%0d exp=2", n_stk);
      end
      for (int k = 25; k <= 40 && first < 0; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL en_resume k=%0d act=%b exp=%b", k, act, ex);
         end
         if (act.tick) first = k;
      end
      n_cmp++;
      if (first != 27) begin
         n_bad++; $display("FAIL en_tick_delay act=%0d exp=27", first);
      end
   endtask

   task automatic test_clear;
      out_t act, ex;
      int   first;
      first = -1;
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL clr_pre k=%0d act=%b exp=%b", k, act, ex);
         end
      end
      run_cycle(1'b0, 1'b1, 1'b1, act);
      ex = sb.pop_front();
      n_cmp++;
      if (act !== ex || act.blink !== 1'b0 || act.tick !== 1'b0) begin
         n_bad++; $display("FAIL clr_edge act=%b exp=%b", act, ex);
      end
      for (int k = 20; k <= 34 && first < 0; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL clr_post k=%0d act=%b exp=%b", k, act, ex);
         end
         if (act.tick) first = k;
      end
      n_cmp++;
      if (first != 29) begin
         n_bad++; $display("FAIL clr_next_tick act=%0d exp=29", first);
      end
   endtask

   task automatic test_async_reset;
      out_t act, ex;
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         run_cycle(1'b0, 1'b1, 1'b0, act);
         ex = sb.pop_front();
         n_cmp++;
         if (act !== ex) begin
            n_bad++; $display("FAIL arst_pre k=%0d act=%b exp=%b", k, act, ex);
         end
      end
      n_cmp++;
      if (act.scan !== SW'(2)) begin
         n_bad++; $display("FAIL arst_scan_before act=%0d exp=2", act.scan);
      end
      #2 rst_n = 1'b0;
      #1;
      act = {bus.tick_o, bus.blink_o, bus.test_o, bus.scan_o, bus.scan_tick_o};
      n_cmp++;
      if (act !== '0) begin
         n_bad++; $display("FAIL arst_immediate act=%b exp=%b", act, 6'b0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_normal("arst_restart");
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_normal("normal");
      test_scan();
      test_mode();
      test_enable();
      test_clear();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised timebase for the real-time-clock display path. Generates a one-cycle time-advance tick (normal or fast test rate), a 50 % blink signal for the colon/dot, and a multiplexed-display scan index with its own prescaler. Sits between the board clock and the counting and 7-segment display blocks. Downstream logic runs on `clk_i` and uses `tick_o` as a clock enable, not as a derived clock.

## Interface
Parameters:
- `DIV_NORM`, 100000000: normal tick period in `clk_i` cycles (1 s at 100 MHz); simulation uses 1000; ≥ 2.
- `DIV_FAST`, 10: test-mode tick period in cycles; ≥ 2.
- `DIV_SCAN`, 25000: scan step period in cycles (~250 µs at 100 MHz); ≥ 2; simulation uses 25.
- `N_DIGITS`, 8: number of multiplexed digits; ≥ 2; need not be a power of two.
- `SCAN_W`, 3: width of `scan_o`; must satisfy 2^SCAN_W ≥ N_DIGITS.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `test_i` in 1: raw test-mode button, asynchronous, active-high.
- `en_i` in 1: count enable for the tick and blink counters; when 0 they hold.
- `clr_i` in 1: synchronous phase restart of the tick and blink counters.
- `tick_o` out 1: one-cycle time-advance pulse.
- `blink_o` out 1: 50 % square wave, period `DIV_NORM`.
- `test_o` out 1: synchronised test-mode state.
- `scan_o` out SCAN_W: active digit index, 0..N_DIGITS-1.
- `scan_tick_o` out 1: one-cycle pulse coincident with each `scan_o` change.

## Operation
- Reset (`rst_i`=0, any time, including mid-period): all counters 0; `tick_o`, `blink_o`, `test_o`, `scan_tick_o` = 0; `scan_o` = 0. Effect is immediate and asynchronous.
- Test-mode sync: `test_i` passes through a 2-FF synchroniser; the second stage is `test_o`.
- Normal counter `cn`, 32 bits: when `en_i`=1, counts 0..DIV_NORM-1 and wraps to 0.
- Fast counter `cf`, 32 bits: when `en_i`=1, counts 0..DIV_FAST-1 and wraps to 0.
- Tick:
  - `test_o`=0: `tick_o` is registered `(cn==DIV_NORM-1) & en_i`.
  - `test_o`=1: `tick_o` is registered `(cf==DIV_FAST-1) & en_i`.
- Mode change: in any cycle where `test_o` differs from its previous value:
  - `cf` is cleared to 0.
  - `tick_o` is forced to 0 on the next edge.
  - The first fast tick therefore occurs a full `DIV_FAST` enabled cycles later.
  - `cn` is not disturbed, so blink phase is continuous across modes.
- Blink: `blink_o` is registered `(cn >= DIV_NORM/2)` using integer division. It depends only on `cn` and is unaffected by test mode.
- `clr_i`=1: `cn` and `cf` go to 0 and `tick_o` and `blink_o` go to 0 on the next edge. `clr_i` has priority over `en_i` and over wrap. The scan path is unaffected.
- Scan prescaler `cs`: free-running regardless of `en_i` and `clr_i`; counts 0..DIV_SCAN-1.
  - On wrap, `scan_o` advances: `scan_o`+1, or 0 if `scan_o`==N_DIGITS-1.
  - `scan_tick_o` is 1 in the same cycle that the new `scan_o` value appears.
- Holding `en_i`=0 freezes `cn` and `cf`. `tick_o` is 0 while frozen. `blink_o` holds its value.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- With `en_i`=1 from reset release, the first `tick_o` is high in the cycle after edge `DIV_NORM`. It then repeats every `DIV_NORM` cycles, or every `DIV_FAST` in test mode.
- `test_i` to `test_o` latency: 2 clocks.
- First `scan_tick_o` occurs `DIV_SCAN` cycles after reset release. Full digit cycle length is `N_DIGITS`·`DIV_SCAN` clocks.
- Tick latency from the `clr_i` edge: the next tick follows exactly `DIV_NORM` (or `DIV_FAST`) enabled cycles later.

## Test plan
Parameters for all scenarios: `DIV_NORM`=10, `DIV_FAST`=3, `DIV_SCAN`=4, `N_DIGITS`=3, `SCAN_W`=2.
- Reset release, `en_i`=1, `test_i`=0 for 40 cycles → `tick_o` pulses exactly 4 times, 10 cycles apart, each 1 cycle wide. `blink_o` is low 5 cycles and high 5 cycles per period.
- Scan sequence, 40 cycles → `scan_o` runs 0,1,2,0,1,2,… with each value held 4 cycles. `scan_tick_o` fires 10 times.
- Raise `test_i` mid-period → `test_o` rises 2 clocks later, with no tick in the switch cycle. Fast ticks then follow every 3 cycles and `blink_o` keeps its 10-cycle period. Dropping `test_i` returns ticks to the 10-cycle period.
- `en_i`=0 for 7 cycles mid-period → no tick and `blink_o` holds. After re-enable, the tick is delayed by exactly 7 cycles. Scan is unaffected.
- `clr_i` pulse at `cn`=8 → no tick at the old boundary. The next tick comes 10 cycles after the clear. `blink_o` is 0 right after the clear.
- Assert `rst_i`=0 asynchronously mid-period with `scan_o`=2 → all outputs are 0 immediately. After release, the sequence restarts as in scenario 1.
